demux1x8_collector: RTL and testbench

- Receive-side counterpart of the 8:1 bit multiplexer: takes one data bit plus a 3-bit slot select per transfer and scatters it into an 8-bit word.
- Tracks which slots are filled. Once all 8 distinct slots are written, presents the assembled word on a valid/ready output handshake.
- Includes a timeout that aborts a partially collected word.
- Sits downstream of a bit-serialising MUX source, e.g. a scanned 8:1 select sequence.

---
 rtl/demux1x8_collector.sv | 76 +++++++
 tb/tb_demux1x8_collector.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/demux1x8_collector.sv
// demux1x8_collector: scatters serial bits into an 8-bit word by slot index and hands it off via valid/ready; DEMUX_PARITY_EN adds out_parity.
module demux1x8_collector #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic [2:0] sett,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] data_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] fill_map,
  output logic       dup_err,
  output logic       timeout
`ifdef DEMUX_PARITY_EN
  ,
  output logic       out_parity
`endif
);
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  state_t state;
  logic [7:0] cnt, wr_data, wr_fill;
  logic acc;
  assign in_ready = state != HOLD;
  assign acc = in_valid && in_ready;
  // fill_map is always zero in IDLE, so only data needs clearing on the first write
  always_comb begin
    wr_data = state == IDLE ? 8'h00 : data_out;
    wr_data[sett] = din;
    wr_fill = fill_map | (8'h01 << sett);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data_out <= 8'h00;
      fill_map <= 8'h00;
      out_valid <= 1'b0;
      dup_err <= 1'b0;
      timeout <= 1'b0;
      cnt <= 8'h00;
`ifdef DEMUX_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      dup_err <= 1'b0;
      timeout <= 1'b0;
      if (state == HOLD) begin
        if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          fill_map <= 8'h00;
        end
      end else if (acc) begin
        data_out <= wr_data;
        fill_map <= wr_fill;
        cnt <= 8'h00;
        dup_err <= fill_map[sett];
        state <= &wr_fill ? HOLD : COLLECT;
        out_valid <= &wr_fill;
`ifdef DEMUX_PARITY_EN
        if (&wr_fill) out_parity <= ^wr_data;
`endif
      end else if (state == COLLECT) begin
        if (cnt == 8'(TIMEOUT - 1)) begin
          state <= IDLE;
          fill_map <= 8'h00;
          data_out <= 8'h00;
          timeout <= 1'b1;
          cnt <= 8'h00;
        end else cnt <= cnt + 8'h01;
      end
    end
  end
endmodule

// File: tb/tb_demux1x8_collector.sv
// tb_demux1x8_collector: directed self-checking bench for demux1x8_collector.
module tb_demux1x8_collector;
  logic clk = 0, rst = 0, din = 0, in_valid = 0, out_ready = 0;
  logic [2:0] sett = 0;
  logic in_ready, out_valid, dup_err, timeout;
  logic [7:0] data_out, fill_map;
  int checks = 0, errors = 0;
`ifdef DEMUX_PARITY_EN
  logic out_parity;
`endif
  demux1x8_collector #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .din(din), .sett(sett), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .fill_map(fill_map), .dup_err(dup_err), .timeout(timeout)
`ifdef DEMUX_PARITY_EN
    , .out_parity(out_parity)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] s, input logic d);
    sett = s;
    din = d;
    in_valid = 1;
    tick();
  endtask
  task automatic test_reset();
    rst = 1;
    tick();
    rst = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_out); end
    checks++; if (fill_map !== 8'h00) begin errors++; $display("FAIL reset_fill: got %h want 00", fill_map); end
    checks++; if (dup_err !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_pulses: got dup=%b to=%b want 0 0", dup_err, timeout); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask
  task automatic test_basic();
    logic [7:0] w = 8'h8d;
    out_ready = 1;
    for (int i = 0; i < 7; i++) wr(3'(i), w[i]);
    checks++; if (fill_map !== 8'h7F || out_valid !== 1'b0) begin errors++; $display("FAIL basic_partial: got fill=%h valid=%b want 7f 0", fill_map, out_valid); end
    wr(3'd7, w[7]);
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    checks++; if (data_out !== 8'h8d) begin errors++; $display("FAIL basic_data: got %h want 8d", data_out); end
    checks++; if (fill_map !== 8'hFF || in_ready !== 1'b0) begin errors++; $display("FAIL basic_hold: got fill=%h ready=%b want ff 0", fill_map, in_ready); end
`ifdef DEMUX_PARITY_EN
    checks++; if (out_parity !== 1'b0) begin errors++; $display("FAIL basic_parity: got %b want 0", out_parity); end
`endif
    tick();
    checks++; if (out_valid !== 1'b0 || fill_map !== 8'h00) begin errors++; $display("FAIL basic_handoff: got valid=%b fill=%h want 0 00", out_valid, fill_map); end
    checks++; if (data_out !== 8'h8d || in_ready !== 1'b1) begin errors++; $display("FAIL basic_keep: got data=%h ready=%b want 8d 1", data_out, in_ready); end
  endtask
  task automatic test_hold();
    logic [7:0] w = 8'hA5;
    out_ready = 0;
    for (int i = 7; i >= 0; i--) begin
      wr(3'(i), w[i]);
      in_valid = 0;
      if (i != 0) begin
        tick();
        tick();
      end
    end
    sett = 3'd0;
    din = 0;
    in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_valid !== 1'b1 || data_out !== 8'hA5 || in_ready !== 1'b0 || fill_map !== 8'hFF) begin errors++; $display("FAIL hold_%0d: got valid=%b data=%h ready=%b fill=%h want 1 a5 0 ff", k, out_valid, data_out, in_ready, fill_map); end
      tick();
    end
    checks++; if (out_valid !== 1'b1 || data_out !== 8'hA5) begin errors++; $display("FAIL hold_last: got valid=%b data=%h want 1 a5", out_valid, data_out); end
`ifdef DEMUX_PARITY_EN
    checks++; if (out_parity !== 1'b0) begin errors++; $display("FAIL hold_parity: got %b want 0", out_parity); end
`endif
    out_ready = 1;
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b0 || fill_map !== 8'h00 || data_out !== 8'hA5) begin errors++; $display("FAIL hold_release: got valid=%b fill=%h data=%h want 0 00 a5", out_valid, fill_map, data_out); end
  endtask
  task automatic test_dup();
    logic [2:0] rest [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
    out_ready = 1;
    wr(3'd3, 1'b1);
    checks++; if (dup_err !== 1'b0) begin errors++; $display("FAIL dup_first: got %b want 0", dup_err); end
    wr(3'd3, 1'b0);
    checks++; if (dup_err !== 1'b1 || fill_map !== 8'h08) begin errors++; $display("FAIL dup_pulse: got dup=%b fill=%h want 1 08", dup_err, fill_map); end
    for (int i = 0; i < 7; i++) begin
      wr(rest[i], 1'b1);
      if (i < 6) begin
        checks++; if (dup_err !== 1'b0) begin errors++; $display("FAIL dup_clear_%0d: got %b want 0", i, dup_err); end
      end
    end
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || data_out !== 8'hF7) begin errors++; $display("FAIL dup_result: got valid=%b data=%h want 1 f7", out_valid, data_out); end
`ifdef DEMUX_PARITY_EN
    checks++; if (out_parity !== 1'b1) begin errors++; $display("FAIL dup_parity: got %b want 1", out_parity); end
`endif
    tick();
  endtask
  task automatic test_timeout();
    logic [7:0] w = 8'h3C;
    out_ready = 1;
    for (int i = 0; i < 3; i++) wr(3'(i), 1'b1);
    in_valid = 0;
    for (int k = 1; k < 16; k++) begin
      tick();
      checks++; if (timeout !== 1'b0 || fill_map !== 8'h07) begin errors++; $display("FAIL to_wait_%0d: got to=%b fill=%h want 0 07", k, timeout, fill_map); end
    end
    tick();
    checks++; if (timeout !== 1'b1 || fill_map !== 8'h00 || data_out !== 8'h00 || in_ready !== 1'b1) begin errors++; $display("FAIL to_fire: got to=%b fill=%h data=%h ready=%b want 1 00 00 1", timeout, fill_map, data_out, in_ready); end
    tick();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_once: got %b want 0", timeout); end
    for (int i = 0; i < 8; i++) wr(3'(i), w[i]);
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || data_out !== 8'h3C) begin errors++; $display("FAIL to_fresh: got valid=%b data=%h want 1 3c", out_valid, data_out); end
    tick();
  endtask
  task automatic test_rst_mid();
    logic [7:0] w = 8'h8d;
    for (int i = 0; i < 5; i++) wr(3'(i), 1'b1);
    in_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    checks++; if (fill_map !== 8'h00 || data_out !== 8'h00) begin errors++; $display("FAIL rstmid_clear: got fill=%h data=%h want 00 00", fill_map, data_out); end
    for (int i = 0; i < 8; i++) wr(3'(i), w[i]);
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || data_out !== 8'h8d) begin errors++; $display("FAIL rstmid_result: got valid=%b data=%h want 1 8d", out_valid, data_out); end
    tick();
  endtask
  task automatic test_rst_hold();
    out_ready = 0;
    for (int i = 0; i < 8; i++) wr(3'(i), 1'b1);
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || data_out !== 8'hFF) begin errors++; $display("FAIL rsthold_pre: got valid=%b data=%h want 1 ff", out_valid, data_out); end
    rst = 1;
    tick();
    rst = 0;
    checks++; if (out_valid !== 1'b0 || data_out !== 8'h00 || in_ready !== 1'b1) begin errors++; $display("FAIL rsthold_post: got valid=%b data=%h ready=%b want 0 00 1", out_valid, data_out, in_ready); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_dup();
    test_timeout();
    test_rst_mid();
    test_rst_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
